// File: rtl/rf_writeback_queue_if.sv
// Write-port / scoreboard bundle for rf_writeback_queue.
// master: the pipeline/control side driving requests and sampling results.
// slave:  the rf_writeback_queue itself.
interface rf_writeback_queue_if;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_wdata;
  logic        ll_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_w_data;

  modport master (
    output pipe_wen, pipe_rd, pipe_wdata,
    output issue_valid, issue_rd,
    output ll_valid, ll_rd, ll_wdata,
    output rs1, rs2,
    input  issue_ready, ll_ready, stall,
    input  rf_wen, rf_rd, rf_w_data
  );

  modport slave (
    input  pipe_wen, pipe_rd, pipe_wdata,
    input  issue_valid, issue_rd,
    input  ll_valid, ll_rd, ll_wdata,
    input  rs1, rs2,
    output issue_ready, ll_ready, stall,
    output rf_wen, rf_rd, rf_w_data
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: arbitrates the register-file write port between
// single-cycle pipeline writebacks (highest priority) and a FIFO of
// out-of-order long-latency results, and keeps a pending-destination
// scoreboard that drives the RAW stall.
// Optional feature macro: RF_WB_BYPASS_EN -- a long-latency result that
// finds the FIFO empty and the port free is written in the same cycle
// instead of being enqueued.
module rf_writeback_queue #(
  parameter int DEPTH = 4
) (
  input logic                CLK,
  input logic                nRST,
  rf_writeback_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]    mem_rd_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   sb_q, sb_d;

  logic          fifo_empty, fifo_full;
  logic          push, pop, bypass, issue_fire, clr_en;
  logic [4:0]    head_rd, clr_rd, sel_rd;
  logic [31:0]   head_data, sel_data;
  logic          sel_valid;

  // Port arbitration, FIFO/scoreboard next state and the visible outputs.
  always_comb begin
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == DEPTH_C);
    head_rd    = mem_rd_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];
`ifdef RF_WB_BYPASS_EN
    bypass     = bus.ll_valid && fifo_empty && !bus.pipe_wen;
`else
    bypass     = 1'b0;
`endif
    pop        = !bus.pipe_wen && !fifo_empty;
    push       = bus.ll_valid && !fifo_full && !bypass;
    issue_fire = bus.issue_valid && !sb_q[bus.issue_rd] && (cnt_q < DEPTH_C) &&
                 (bus.issue_rd != 5'd0);

    // Pipeline first, then the queued head, then a bypassed result.
    sel_valid = 1'b0;
    sel_rd    = bus.pipe_rd;
    sel_data  = bus.pipe_wdata;
    if (bus.pipe_wen) begin
      sel_valid = 1'b1;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_rd    = head_rd;
      sel_data  = head_data;
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_rd    = bus.ll_rd;
      sel_data  = bus.ll_wdata;
    end

    // A long-latency result leaving the block releases its destination.
    clr_en = pop || bypass;
    clr_rd = pop ? head_rd : bus.ll_rd;

    sb_d  = sb_q;
    cnt_d = cnt_q;
    if (clr_en && clr_rd != 5'd0) begin
      sb_d[clr_rd] = 1'b0;
      // A result with no pending bit is tolerated but must not skew the count.
      if (sb_q[clr_rd]) cnt_d = cnt_d - CW'(1);
    end
    if (issue_fire) begin
      sb_d[bus.issue_rd] = 1'b1;
      cnt_d = cnt_d + CW'(1);
    end
    sb_d[0] = 1'b0;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) occ_d = occ_q + CW'(1);
    if (pop && !push) occ_d = occ_q - CW'(1);

    // Outputs are forced to their idle values while reset is held.
    bus.rf_wen      = nRST && sel_valid && (sel_rd != 5'd0);
    bus.rf_rd       = sel_rd;
    bus.rf_w_data   = sel_data;
    bus.issue_ready = !nRST || (!sb_q[bus.issue_rd] && (cnt_q < DEPTH_C));
    bus.ll_ready    = !nRST || !fifo_full;
    bus.stall       = nRST && (((bus.rs1 != 5'd0) && sb_q[bus.rs1]) ||
                               ((bus.rs2 != 5'd0) && sb_q[bus.rs2]));
  end

  // Control state: pointers, occupancy, scoreboard and outstanding count.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      sb_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      sb_q     <= sb_d;
    end
  end

  // Result storage; contents need no reset because occupancy gates reads.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= bus.ll_rd;
      mem_data_q[wr_ptr_q] <= bus.ll_wdata;
    end
  end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios followed by a randomized
// run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic nrst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rf_writeback_queue_if bus();
  rf_writeback_queue #(.DEPTH(DEPTH)) dut (.CLK(clk), .nRST(nrst), .bus(bus));

  // Reference model state: queued results, pending set and outstanding count.
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_data[$];
  logic        m_pend [32];
  int          m_cnt;
  logic        exp_wen, exp_ir, exp_lr, exp_stall, m_byp;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, want done)");
    $fatal(1);
  end

  task automatic set_idle();
    bus.pipe_wen = 1'b0; bus.pipe_rd = '0; bus.pipe_wdata = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.ll_valid = 1'b0; bus.ll_rd = '0; bus.ll_wdata = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); set_idle(); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
  endtask

  task automatic model_clear();
    mq_rd.delete(); mq_data.delete(); m_cnt = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
  endtask

  // Expected combinational outputs from the model and current inputs.
  task automatic model_eval();
    exp_ir    = !m_pend[bus.issue_rd] && (m_cnt < DEPTH);
    exp_lr    = mq_rd.size() < DEPTH;
    exp_stall = (bus.rs1 != 0 && m_pend[bus.rs1]) || (bus.rs2 != 0 && m_pend[bus.rs2]);
`ifdef RF_WB_BYPASS_EN
    m_byp = bus.ll_valid && mq_rd.size() == 0 && !bus.pipe_wen;
`else
    m_byp = 1'b0;
`endif
    exp_wen = 1'b0; exp_rd = '0; exp_data = '0;
    if (bus.pipe_wen) begin
      exp_rd = bus.pipe_rd; exp_data = bus.pipe_wdata; exp_wen = (bus.pipe_rd != 0);
    end else if (mq_rd.size() > 0) begin
      exp_rd = mq_rd[0]; exp_data = mq_data[0]; exp_wen = (mq_rd[0] != 0);
    end else if (m_byp) begin
      exp_rd = bus.ll_rd; exp_data = bus.ll_wdata; exp_wen = (bus.ll_rd != 0);
    end
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_commit();
    logic        do_pop, do_push, do_clr;
    logic [4:0]  crd;
    do_pop  = !bus.pipe_wen && mq_rd.size() > 0;
    do_push = bus.ll_valid && exp_lr && !m_byp;
    do_clr  = do_pop || m_byp;
    crd     = do_pop ? mq_rd[0] : bus.ll_rd;
    if (do_clr && crd != 0 && m_pend[crd]) begin
      m_pend[crd] = 1'b0; m_cnt--;
    end
    if (bus.issue_valid && exp_ir && bus.issue_rd != 0) begin
      m_pend[bus.issue_rd] = 1'b1; m_cnt++;
    end
    if (do_pop) begin void'(mq_rd.pop_front()); void'(mq_data.pop_front()); end
    if (do_push) begin mq_rd.push_back(bus.ll_rd); mq_data.push_back(bus.ll_wdata); end
  endtask

  task automatic test_reset();
    @(negedge clk); set_idle(); nrst = 1'b0;
    bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h11; bus.rs1 = 5'd3;
    #1; checks++;
    if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen_in_reset got %b want 0", bus.rf_wen); end
    @(negedge clk); set_idle(); #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready); end
    checks++; if (bus.ll_ready !== 1'b1) begin errors++; $display("FAIL reset_ll_ready got %b want 1", bus.ll_ready); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    @(negedge clk); nrst = 1'b1; bus.rs1 = 5'd3; bus.rs2 = 5'd9; #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL idle_rf_wen got %b want 0", bus.rf_wen); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b want 0", bus.stall); end
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL idle_issue_ready got %b want 1", bus.issue_ready); end
    checks++; if (bus.ll_ready !== 1'b1) begin errors++; $display("FAIL idle_ll_ready got %b want 1", bus.ll_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bus.ll_valid = (c == 0); bus.ll_rd = 5'd0; bus.ll_wdata = 32'h0; #1;
      checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL x0_write cycle %0d got rf_wen=%b want 0", c, bus.rf_wen); end
    end
  endtask

  task automatic test_raw_stall();
    do_reset();
    @(negedge clk); bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs1 = 5'd5; #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL raw_issue_ready got %b want 1", bus.issue_ready); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_stall_before got %b want 0", bus.stall); end
    @(negedge clk); bus.issue_valid = 1'b0;
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd5; bus.ll_wdata = 32'hDEADBEEF; #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall_set got %b want 1", bus.stall); end
    checks++; if (bus.ll_ready !== 1'b1) begin errors++; $display("FAIL raw_ll_ready got %b want 1", bus.ll_ready); end
`ifdef RF_WB_BYPASS_EN
    checks++; if ({bus.rf_wen, bus.rf_rd, bus.rf_w_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL raw_bypass_write got wen=%b rd=%0d data=%h want 1/5/deadbeef", bus.rf_wen, bus.rf_rd, bus.rf_w_data); end
    @(negedge clk); bus.ll_valid = 1'b0; #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_stall_clear got %b want 0", bus.stall); end
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL raw_after_write got %b want 0", bus.rf_wen); end
`else
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL raw_no_same_cycle got %b want 0", bus.rf_wen); end
    @(negedge clk); bus.ll_valid = 1'b0; #1;
    checks++; if ({bus.rf_wen, bus.rf_rd, bus.rf_w_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL raw_queued_write got wen=%b rd=%0d data=%h want 1/5/deadbeef", bus.rf_wen, bus.rf_rd, bus.rf_w_data); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall_on_write got %b want 1", bus.stall); end
    @(negedge clk); #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_stall_clear got %b want 0", bus.stall); end
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL raw_after_write got %b want 0", bus.rf_wen); end
`endif
  endtask

  task automatic test_pipe_priority();
    do_reset();
    @(negedge clk); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd7;
    @(negedge clk); bus.issue_valid = 1'b0;
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd7; bus.ll_wdata = 32'h77;
    bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h11;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(negedge clk); bus.ll_valid = 1'b0; end
      #1;
      checks++; if ({bus.rf_wen, bus.rf_rd, bus.rf_w_data} !== {1'b1, 5'd3, 32'h11}) begin
        errors++; $display("FAIL pipe_first cycle %0d got wen=%b rd=%0d data=%h want 1/3/11", c, bus.rf_wen, bus.rf_rd, bus.rf_w_data); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL pipe_stall_hold cycle %0d got %b want 1", c, bus.stall); end
    end
    @(negedge clk); bus.pipe_wen = 1'b0; #1;
    checks++; if ({bus.rf_wen, bus.rf_rd, bus.rf_w_data} !== {1'b1, 5'd7, 32'h77}) begin
      errors++; $display("FAIL pipe_then_queue got wen=%b rd=%0d data=%h want 1/7/77", bus.rf_wen, bus.rf_rd, bus.rf_w_data); end
    @(negedge clk); #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL pipe_drained got %b want 0", bus.rf_wen); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL pipe_stall_clear got %b want 0", bus.stall); end
  endtask

  task automatic test_issue_limit();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); bus.issue_valid = 1'b1; bus.issue_rd = 5'(i); #1;
      checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL issue_accept rd %0d got %b want 1", i, bus.issue_ready); end
    end
    @(negedge clk); bus.issue_valid = 1'b0; bus.issue_rd = 5'd6;
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd1; bus.ll_wdata = 32'hA1; #1;
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL issue_full got %b want 0", bus.issue_ready); end
    @(negedge clk); bus.ll_valid = 1'b0;
    @(negedge clk); bus.issue_rd = 5'd6; #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL issue_after_pop got %b want 1", bus.issue_ready); end
    bus.issue_rd = 5'd2; #1;
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL issue_waw_block got %b want 0", bus.issue_ready); end
    bus.issue_rd = 5'd1; #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL issue_cleared_rd got %b want 1", bus.issue_ready); end
  endtask

  task automatic test_fifo_full();
    logic [4:0] order [4];
    order[0] = 5'd10; order[1] = 5'd8; order[2] = 5'd11; order[3] = 5'd9;
    do_reset();
    for (int i = 8; i <= 11; i++) begin
      @(negedge clk); bus.issue_valid = 1'b1; bus.issue_rd = 5'(i);
    end
    @(negedge clk); bus.issue_valid = 1'b0;
    bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h11;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      bus.ll_valid = 1'b1; bus.ll_rd = order[k]; bus.ll_wdata = 32'h100 + 32'(order[k]); #1;
      checks++; if (bus.ll_ready !== 1'b1) begin errors++; $display("FAIL fill_ll_ready entry %0d got %b want 1", k, bus.ll_ready); end
    end
    @(negedge clk); bus.ll_valid = 1'b0; #1;
    checks++; if (bus.ll_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ll_ready got %b want 0", bus.ll_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); bus.pipe_wen = 1'b0; bus.rs1 = (k > 0) ? order[k-1] : 5'd0; bus.rs2 = 5'd0; #1;
      if (k == 0) begin
        checks++; if (bus.ll_ready !== 1'b0) begin errors++; $display("FAIL pop_no_ready_same_cycle got %b want 0", bus.ll_ready); end
      end else begin
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL drain_prev_cleared k %0d got %b want 0", k, bus.stall); end
      end
      bus.rs1 = order[k]; #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL drain_cur_pending k %0d got %b want 1", k, bus.stall); end
      checks++; if ({bus.rf_wen, bus.rf_rd, bus.rf_w_data} !== {1'b1, order[k], 32'h100 + 32'(order[k])}) begin
        errors++; $display("FAIL drain_order k %0d got wen=%b rd=%0d data=%h want rd=%0d", k, bus.rf_wen, bus.rf_rd, bus.rf_w_data, order[k]); end
    end
    @(negedge clk); bus.rs1 = order[3]; #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL drain_last_cleared got %b want 0", bus.stall); end
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL drain_done got %b want 0", bus.rf_wen); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    @(negedge clk); bus.issue_rd = 5'd13;
    @(negedge clk); bus.issue_valid = 1'b0; bus.pipe_wen = 1'b1; bus.pipe_rd = 5'd4; bus.pipe_wdata = 32'h44;
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd12; bus.ll_wdata = 32'hC12;
    @(negedge clk); bus.ll_rd = 5'd13; bus.ll_wdata = 32'hC13;
    @(negedge clk); set_idle(); nrst = 1'b0; #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL midreset_no_write got %b want 0", bus.rf_wen); end
    @(negedge clk); nrst = 1'b1; bus.rs1 = 5'd12; bus.rs2 = 5'd13; bus.issue_rd = 5'd12; #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL midreset_sb_clear got %b want 0", bus.stall); end
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL midreset_fifo_empty got %b want 0", bus.rf_wen); end
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL midreset_issue_ready got %b want 1", bus.issue_ready); end
    @(negedge clk); #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL midreset_no_late_write got %b want 0", bus.rf_wen); end
  endtask

  task automatic test_random();
    logic [4:0]  outst[$];
    logic        hold;
    logic [4:0]  h_rd;
    logic [31:0] h_data;
    do_reset();
    model_clear();
    hold = 1'b0; h_rd = '0; h_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!hold && outst.size() > 0 && $urandom_range(0, 2) != 0) begin
        int k;
        k = $urandom_range(0, outst.size() - 1);
        h_rd = outst[k]; outst.delete(k); h_data = $urandom; hold = 1'b1;
      end
      bus.ll_valid = hold; bus.ll_rd = h_rd; bus.ll_wdata = h_data;
      bus.pipe_wen = ((cyc % 100) < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.pipe_rd = 5'($urandom); bus.pipe_wdata = $urandom;
      bus.issue_valid = 1'($urandom_range(0, 1)); bus.issue_rd = 5'($urandom_range(0, 15));
      bus.rs1 = 5'($urandom_range(0, 15)); bus.rs2 = 5'($urandom_range(0, 15));
      #1; model_eval();
      checks++; if (bus.issue_ready !== exp_ir) begin errors++; $display("FAIL rand_issue_ready cyc %0d got %b want %b", cyc, bus.issue_ready, exp_ir); end
      checks++; if (bus.ll_ready !== exp_lr) begin errors++; $display("FAIL rand_ll_ready cyc %0d got %b want %b", cyc, bus.ll_ready, exp_lr); end
      checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL rand_stall cyc %0d got %b want %b", cyc, bus.stall, exp_stall); end
      checks++; if (bus.rf_wen !== exp_wen) begin errors++; $display("FAIL rand_rf_wen cyc %0d got %b want %b", cyc, bus.rf_wen, exp_wen); end
      if (exp_wen) begin
        checks++; if ({bus.rf_rd, bus.rf_w_data} !== {exp_rd, exp_data}) begin
          errors++; $display("FAIL rand_rf_write cyc %0d got rd=%0d data=%h want rd=%0d data=%h", cyc, bus.rf_rd, bus.rf_w_data, exp_rd, exp_data); end
      end
      if (hold && exp_lr) hold = 1'b0;
      if (bus.issue_valid && exp_ir && bus.issue_rd != 0) outst.push_back(bus.issue_rd);
      model_commit();
    end
  endtask

  initial begin
    set_idle();
    nrst = 1'b0;
    test_reset();
    test_raw_stall();
    test_pipe_priority();
    test_issue_limit();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
